// File: rtl/bpfcap_pkg.sv
// Shared types and helpers for the packet transmit path.
//   tx_state_t     : transmit controller states
//   BYTES_PER_WORD : bytes carried by one memory/stream word
//   words_of(len)  : number of words needed to carry len bytes, ceil(len/4)
//   empty_of(len)  : unused bytes in the final word, (4 - len%4) % 4
package bpfcap_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} tx_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int PKT_LEN_W      = 16;

    function automatic logic [PKT_LEN_W-2:0] words_of(input logic [PKT_LEN_W-1:0] len);
        return (PKT_LEN_W-1)'(({1'b0, len} + (PKT_LEN_W+1)'(BYTES_PER_WORD-1)) >> 2);
    endfunction

    // Two's-complement of the low bits gives (4 - len%4) % 4 directly.
    function automatic logic [1:0] empty_of(input logic [PKT_LEN_W-1:0] len);
        return 2'd0 - len[1:0];
    endfunction

endpackage

// File: rtl/pkt_tx_fifo.sv
// Synchronous show-ahead FIFO used to buffer read-master returns.
// Ports:
//   clk, reset (async, active-low)
//   push/wdata : write side, ignored when full
//   pop/rdata  : read side, rdata is the head entry whenever !empty
//   full, empty, count : occupancy status
module pkt_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pkt_tx.sv
// Packet transmit engine: on a start request, reads ceil(pkt_len/4) words
// from memory through an Avalon-MM read master into a FIFO and replays them
// as an Avalon-ST packet (sop/eop/empty).
// Ports:
//   clk, reset (async, active-low)
//   start, base_addr, pkt_len       : request from the control registers
//   busy, done, len_err             : status back to the control registers
//   avm_*                           : Avalon-MM read master
//   st_*                            : Avalon-ST source
//   tx_pkt_cnt, tx_byte_cnt         : statistics, present only when
//                                     PKT_TX_STATS_EN is defined
//
// State | meaning
// IDLE  | waiting for start
// FETCH | issuing reads (credit-limited by FIFO space)
// DRAIN | all reads issued, waiting for returns and stream to empty
// DONE  | one-cycle completion pulse
module pkt_tx
    import bpfcap_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  pkt_len,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop,
`ifdef PKT_TX_STATS_EN
    output logic [31:0]       tx_pkt_cnt,
    output logic [31:0]       tx_byte_cnt,
`endif
    output logic [1:0]        st_empty
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WORD_W = LEN_W - 1;

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  len_r;
    logic [WORD_W-1:0] words_total;
    logic [WORD_W-1:0] words_issued;
    logic [WORD_W-1:0] beat_idx;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic              len_err_r;
    logic              accept;
    logic              ret;
    logic              pop;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;

    assign accept      = avm_read && !avm_waitrequest;
    // Returns outside an active packet (e.g. stragglers after reset) are dropped.
    assign ret         = avm_readdatavalid && (state == FETCH || state == DRAIN);
    assign fifo_push   = ret && !fifo_full;
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign pop         = st_valid && st_ready;

    assign avm_address = addr_r;
    assign len_err     = len_err_r;

    pkt_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (avm_readdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        avm_read  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = (pkt_len != '0) ? FETCH : DONE;
            end
            FETCH: begin
                busy = 1'b1;
                // Only request what the FIFO is guaranteed to absorb.
                avm_read = (words_issued < words_total) &&
                           (credit_used < (CNT_W+1)'(FIFO_DEPTH));
                if (words_issued == words_total) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (outstanding == '0 && fifo_empty) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r       <= '0;
            len_r        <= '0;
            words_total  <= '0;
            words_issued <= '0;
            beat_idx     <= '0;
            outstanding  <= '0;
            len_err_r    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                len_err_r <= (pkt_len == '0);
                len_r     <= pkt_len;
                if (pkt_len != '0) begin
                    addr_r       <= base_addr;
                    words_total  <= words_of(pkt_len);
                    words_issued <= '0;
                    beat_idx     <= '0;
                end
            end
            if (accept) begin
                addr_r       <= addr_r + ADDR_W'(BYTES_PER_WORD);
                words_issued <= words_issued + WORD_W'(1);
            end
            unique case ({accept, ret})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (pop) beat_idx <= beat_idx + WORD_W'(1);
        end
    end

    // Beat attributes derive from beat_idx, which only moves on a transfer,
    // so they hold steady while the sink stalls.
    assign st_valid = !fifo_empty;
    assign st_data  = st_valid ? fifo_rdata : '0;
    assign st_sop   = st_valid && (beat_idx == '0);
    assign st_eop   = st_valid && (beat_idx == words_total - WORD_W'(1));
    assign st_empty = st_eop ? empty_of(len_r) : 2'd0;

`ifdef PKT_TX_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_pkt_cnt  <= '0;
            tx_byte_cnt <= '0;
        end else if (state == DONE && len_r != '0) begin
            tx_pkt_cnt  <= tx_pkt_cnt + 32'd1;
            tx_byte_cnt <= tx_byte_cnt + 32'(len_r);
        end
    end
`endif

endmodule
